hdmi_frame_ctrl: RTL and testbench

- Sits between the HDMI receiver and hdmi_to_blocks, and sequences the block converter on whole, well-formed frames only.
- Arms on v_sync under software control and checks every line length and the frame height against X_RES/Y_RES.
- Forwards a registered, gated copy of the HDMI stream, drops malformed frames, and reports frame-done, error and statistics status.

---
 rtl/hdmi_pkg.sv | 24 ++
 rtl/hdmi_frame_ctrl_if.sv | 26 ++
 rtl/hdmi_line_checker.sv | 54 +++++
 rtl/hdmi_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_hdmi_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hdmi_pkg : shared state encoding, pixel bus type and line-geometry helper
// Rev 1.0
// ---------------------------------------------------------------------------
package hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam int PIX_N = 2;

  typedef logic signed [PIX_N-1:0][7:0] pix_bus_t;

  function automatic int bpl(input int n, input int x_res);
    return x_res / n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_frame_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hdmi_frame_ctrl_if : HDMI pixel stream (syncs, valid, Y/Cr/Cb beats)
// Rev 1.0
// ---------------------------------------------------------------------------
interface hdmi_frame_ctrl_if #(
  parameter int N = 2
);

  logic                     v_sync;
  logic                     h_sync;
  logic                     data_valid;
  logic signed [N-1:0][7:0] data_y;
  logic signed [N-1:0][7:0] data_cr;
  logic signed [N-1:0][7:0] data_cb;

  modport master (
    output v_sync, h_sync, data_valid, data_y, data_cr, data_cb
  );

  modport slave (
    input v_sync, h_sync, data_valid, data_y, data_cr, data_cb
  );

endinterface
`default_nettype wire

// File: rtl/hdmi_line_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hdmi_line_checker : counts beats per valid run and completed lines per frame
// Rev 1.0
// ---------------------------------------------------------------------------
module hdmi_line_checker #(
  parameter int BPL   = 1080,
  parameter int Y_RES = 1200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic valid,
  output logic line_ok,
  output logic line_bad,
  output logic overrun,
  output logic frame_full,
  output logic mid_frame
);

  localparam int BW = $clog2(BPL + 2);
  localparam int LW = $clog2(Y_RES + 1);

  localparam logic [BW-1:0] BPL_B   = BW'(BPL);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BPL + 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(Y_RES - 1);
  localparam logic [LW-1:0] LINE_FULL = LW'(Y_RES);

  logic [BW-1:0] beat_cnt;
  logic [LW-1:0] line_cnt;

  // Line end is the first cycle with valid low after a run.
  assign line_ok    = !valid && (beat_cnt == BPL_B);
  assign line_bad   = !valid && (beat_cnt != '0) && (beat_cnt != BPL_B);
  assign overrun    = valid && (beat_cnt == BPL_B);
  assign frame_full = line_ok && (line_cnt == LINE_LAST);
  assign mid_frame  = (line_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt <= '0;
      line_cnt <= '0;
    end else if (valid) begin
      if (beat_cnt != BEAT_MAX)
        beat_cnt <= beat_cnt + BW'(1);
    end else begin
      beat_cnt <= '0;
      if (line_ok && (line_cnt != LINE_FULL))
        line_cnt <= line_cnt + LW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdmi_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hdmi_frame_ctrl : gates an HDMI stream to whole, well-formed frames only
// Rev 1.0
// ---------------------------------------------------------------------------
module hdmi_frame_ctrl
  import hdmi_pkg::*;
#(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_single,
  hdmi_frame_ctrl_if.slave     hdmi,
  hdmi_frame_ctrl_if.master    fwd,
  output logic                 out_resync,
  output logic                 sts_busy,
  output logic                 sts_frame_done,
  output logic                 sts_err_line,
  output logic                 sts_err_frame,
  output logic [CNT_W-1:0]     sts_frame_cnt,
  output logic [CNT_W-1:0]     sts_drop_cnt
);

  localparam int BPL = bpl(N, X_RES);

  state_t state, state_n;
  logic   single_mode, single_n;
  logic   long_armed;
  logic   pass_beat, done_n, err_line_n, err_frame_n, drop_n;
  logic   line_ok, line_bad, overrun, frame_full, mid_frame;
  logic   stopped;

  hdmi_line_checker #(
    .BPL   (BPL),
    .Y_RES (Y_RES)
  ) u_line_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (hdmi.v_sync),
    .valid      (hdmi.data_valid),
    .line_ok    (line_ok),
    .line_bad   (line_bad),
    .overrun    (overrun),
    .frame_full (frame_full),
    .mid_frame  (mid_frame)
  );

  assign stopped  = !ctrl_enable && !single_mode;
  assign sts_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    single_n    = single_mode;
    pass_beat   = 1'b0;
    done_n      = 1'b0;
    err_line_n  = 1'b0;
    err_frame_n = 1'b0;
    drop_n      = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_enable || ctrl_single) begin
          single_n = ctrl_single && !ctrl_enable;
          state_n  = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (stopped)
          state_n = IDLE;
        else if (hdmi.v_sync)
          state_n = ACTIVE;
        else if (hdmi.data_valid && long_armed)
          err_frame_n = 1'b1;
      end
      ACTIVE: begin
        // v_sync wins over any beat or line event in the same cycle.
        if (hdmi.v_sync) begin
          if (mid_frame) begin
            err_frame_n = 1'b1;
            drop_n      = 1'b1;
          end
        end else if (overrun || line_bad) begin
          err_line_n = 1'b1;
          drop_n     = 1'b1;
          state_n    = DROP;
        end else begin
          pass_beat = hdmi.data_valid;
          if (frame_full) begin
            done_n  = 1'b1;
            state_n = (ctrl_enable && !single_mode) ? WAIT_VS : IDLE;
          end
        end
      end
      DROP: begin
        if (hdmi.v_sync)
          state_n = stopped ? IDLE : ACTIVE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd.v_sync     <= 1'b0;
      fwd.h_sync     <= 1'b0;
      fwd.data_valid <= 1'b0;
      fwd.data_y     <= '0;
      fwd.data_cr    <= '0;
      fwd.data_cb    <= '0;
      out_resync     <= 1'b0;
      sts_frame_done <= 1'b0;
      sts_err_line   <= 1'b0;
      sts_err_frame  <= 1'b0;
      sts_frame_cnt  <= '0;
      sts_drop_cnt   <= '0;
      single_mode    <= 1'b0;
      long_armed     <= 1'b0;
    end else begin
      fwd.v_sync     <= hdmi.v_sync;
      fwd.h_sync     <= hdmi.h_sync;
      fwd.data_valid <= pass_beat;
      fwd.data_y     <= hdmi.data_y;
      fwd.data_cr    <= hdmi.data_cr;
      fwd.data_cb    <= hdmi.data_cb;
      out_resync     <= drop_n;
      sts_frame_done <= done_n;
      sts_err_line   <= err_line_n;
      sts_err_frame  <= err_frame_n;
      single_mode    <= single_n;
      if (done_n)
        sts_frame_cnt <= sts_frame_cnt + CNT_W'(1);
      if (drop_n)
        sts_drop_cnt <= sts_drop_cnt + CNT_W'(1);
      // Armed only between a completed frame and the next v_sync, so a long
      // frame is reported once.
      if (done_n)
        long_armed <= (state_n == WAIT_VS);
      else if ((state != WAIT_VS) || hdmi.v_sync || err_frame_n)
        long_armed <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hdmi_frame_ctrl : directed frame vectors and corner sequences, N=2 16x8
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hdmi_frame_ctrl;
  import hdmi_pkg::*;

  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int Y_RES = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ctrl_enable = 1'b0;
  logic             ctrl_single = 1'b0;
  logic             out_resync, sts_busy, sts_frame_done, sts_err_line, sts_err_frame;
  logic [CNT_W-1:0] sts_frame_cnt, sts_drop_cnt;

  hdmi_frame_ctrl_if #(.N(N)) hdmi_bus ();
  hdmi_frame_ctrl_if #(.N(N)) fwd_bus ();

  hdmi_frame_ctrl #(
    .N(N), .X_RES(X_RES), .Y_RES(Y_RES), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_enable    (ctrl_enable),
    .ctrl_single    (ctrl_single),
    .hdmi           (hdmi_bus),
    .fwd            (fwd_bus),
    .out_resync     (out_resync),
    .sts_busy       (sts_busy),
    .sts_frame_done (sts_frame_done),
    .sts_err_line   (sts_err_line),
    .sts_err_frame  (sts_err_frame),
    .sts_frame_cnt  (sts_frame_cnt),
    .sts_drop_cnt   (sts_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    en;
    bit    single;
    string seq;
    int    fwd;
    int    done;
    int    eline;
    int    eframe;
    int    resync;
    int    fcnt;
    int    dcnt;
    int    busy;
  } vec_t;

  vec_t vecs [9];

  int total = 0;
  int bad   = 0;
  int n_fwd = 0, n_done = 0, n_eline = 0, n_eframe = 0, n_resync = 0;
  int b_fwd, b_done, b_eline, b_eframe, b_resync;
  int seq_no = 0;

  logic        p_vs, p_hs, p_valid, p_rst;
  logic [15:0] p_y, p_cr, p_cb;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_hex(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: remember what the DUT is about to sample, then check its outputs.
  task automatic tick();
    p_vs    = hdmi_bus.v_sync;
    p_hs    = hdmi_bus.h_sync;
    p_valid = hdmi_bus.data_valid;
    p_rst   = rst;
    p_y     = hdmi_bus.data_y;
    p_cr    = hdmi_bus.data_cr;
    p_cb    = hdmi_bus.data_cb;
    @(posedge clk);
    #1;
    check("out_v_sync", int'(fwd_bus.v_sync), p_rst ? 0 : int'(p_vs));
    check("out_h_sync", int'(fwd_bus.h_sync), p_rst ? 0 : int'(p_hs));
    if (fwd_bus.data_valid) begin
      check("fwd_src_valid", int'(p_valid), 1);
      check_hex("out_data_y", fwd_bus.data_y, p_y);
      check_hex("out_data_cr", fwd_bus.data_cr, p_cr);
      check_hex("out_data_cb", fwd_bus.data_cb, p_cb);
    end
    n_fwd    += int'(fwd_bus.data_valid);
    n_done   += int'(sts_frame_done);
    n_eline  += int'(sts_err_line);
    n_eframe += int'(sts_err_frame);
    n_resync += int'(out_resync);
  endtask

  task automatic set_beat(input bit v);
    hdmi_bus.data_valid = v;
    if (v) begin
      hdmi_bus.data_y  = {8'(seq_no), 8'(seq_no + 1)};
      hdmi_bus.data_cr = {8'(seq_no ^ 8'h5a), 8'(~seq_no)};
      hdmi_bus.data_cb = {8'(seq_no * 3), 8'(seq_no + 8'h80)};
      seq_no++;
    end
  endtask

  task automatic send_line(input int n);
    hdmi_bus.h_sync = 1'b1;
    tick();
    hdmi_bus.h_sync = 1'b0;
    repeat (n) begin
      set_beat(1'b1);
      tick();
    end
    set_beat(1'b0);
    tick();
    tick();
  endtask

  task automatic send_vs(input bit with_valid);
    hdmi_bus.v_sync = 1'b1;
    set_beat(with_valid);
    tick();
    hdmi_bus.v_sync = 1'b0;
    set_beat(1'b0);
    tick();
    tick();
  endtask

  // 'V' = v_sync, 'W' = v_sync with a coincident beat, digit = line of that many beats.
  task automatic run_seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (c == "V")      send_vs(1'b0);
      else if (c == "W") send_vs(1'b1);
      else               send_line(int'(c) - int'("0"));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ctrl_enable = 1'b0;
    ctrl_single = 1'b0;
    hdmi_bus.v_sync = 1'b0;
    hdmi_bus.h_sync = 1'b0;
    set_beat(1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic snap();
    b_fwd = n_fwd; b_done = n_done; b_eline = n_eline;
    b_eframe = n_eframe; b_resync = n_resync;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"good_frame",   1'b1, 1'b0, "V88888888",          64,  1, 0, 0, 0, 1, 0, 1};
    vecs[1] = '{"short_line",   1'b1, 1'b0, "V88878888V88888888", 95,  1, 1, 0, 1, 1, 1, 1};
    vecs[2] = '{"long_line",    1'b1, 1'b0, "V98888888",          8,   0, 1, 0, 1, 0, 1, 1};
    vecs[3] = '{"short_frame",  1'b1, 1'b0, "V88888V88888888",    104, 1, 0, 1, 1, 1, 1, 1};
    vecs[4] = '{"single",       1'b0, 1'b1, "V88888888V88888888", 64,  1, 0, 0, 0, 1, 0, 0};
    vecs[5] = '{"long_frame",   1'b1, 1'b0, "V8888888888",        64,  1, 0, 1, 0, 1, 0, 1};
    vecs[6] = '{"vs_beat_mid",  1'b1, 1'b0, "V888W88888888",      88,  1, 0, 1, 1, 1, 1, 1};
    vecs[7] = '{"vs_beat_top",  1'b1, 1'b0, "VW88888888",         64,  1, 0, 0, 0, 1, 0, 1};
    vecs[8] = '{"disabled",     1'b0, 1'b0, "V88888888",          0,   0, 0, 0, 0, 0, 0, 0};

    do_reset();
    check("rst_out_valid", int'(fwd_bus.data_valid), 0);
    check_hex("rst_out_y", fwd_bus.data_y, 16'h0000);
    check("rst_resync", int'(out_resync), 0);
    check("rst_busy", int'(sts_busy), 0);
    check("rst_done", int'(sts_frame_done), 0);
    check("rst_err_line", int'(sts_err_line), 0);
    check("rst_err_frame", int'(sts_err_frame), 0);
    check("rst_frame_cnt", int'(sts_frame_cnt), 0);
    check("rst_drop_cnt", int'(sts_drop_cnt), 0);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      snap();
      ctrl_enable = vecs[k].en;
      ctrl_single = vecs[k].single;
      tick();
      ctrl_single = 1'b0;
      tick();
      run_seq(vecs[k].seq);
      repeat (4) tick();
      check({vecs[k].name, ".fwd_beats"},  n_fwd - b_fwd,       vecs[k].fwd);
      check({vecs[k].name, ".frame_done"}, n_done - b_done,     vecs[k].done);
      check({vecs[k].name, ".err_line"},   n_eline - b_eline,   vecs[k].eline);
      check({vecs[k].name, ".err_frame"},  n_eframe - b_eframe, vecs[k].eframe);
      check({vecs[k].name, ".resync"},     n_resync - b_resync, vecs[k].resync);
      check({vecs[k].name, ".frame_cnt"},  int'(sts_frame_cnt), vecs[k].fcnt);
      check({vecs[k].name, ".drop_cnt"},   int'(sts_drop_cnt),  vecs[k].dcnt);
      check({vecs[k].name, ".busy"},       int'(sts_busy),      vecs[k].busy);
    end

    // Graceful stop mid-frame: frame completes, later frames are ignored.
    do_reset();
    snap();
    ctrl_enable = 1'b1;
    tick();
    run_seq("V8888");
    ctrl_enable = 1'b0;
    run_seq("8888");
    repeat (3) tick();
    check("stop.frame_done", n_done - b_done, 1);
    check("stop.frame_cnt", int'(sts_frame_cnt), 1);
    check("stop.busy", int'(sts_busy), 0);
    run_seq("V88888888");
    check("stop.fwd_beats", n_fwd - b_fwd, 64);

    // Stop while waiting for v_sync returns to IDLE on the next cycle.
    do_reset();
    ctrl_enable = 1'b1;
    tick();
    check("wait_stop.busy_on", int'(sts_busy), 1);
    ctrl_enable = 1'b0;
    tick();
    check("wait_stop.busy_off", int'(sts_busy), 0);

    // A single request while already busy in continuous mode changes nothing.
    do_reset();
    snap();
    ctrl_enable = 1'b1;
    tick();
    ctrl_single = 1'b1;
    tick();
    ctrl_single = 1'b0;
    run_seq("V88888888V88888888");
    repeat (3) tick();
    check("single_busy.fwd_beats", n_fwd - b_fwd, 128);
    check("single_busy.frame_cnt", int'(sts_frame_cnt), 2);
    check("single_busy.busy", int'(sts_busy), 1);

    // Reset in the middle of a line: everything clears, no resync is emitted.
    do_reset();
    ctrl_enable = 1'b1;
    tick();
    run_seq("V888");
    repeat (4) begin
      set_beat(1'b1);
      tick();
    end
    snap();
    rst = 1'b1;
    set_beat(1'b1);
    tick();
    check("midrst.out_valid", int'(fwd_bus.data_valid), 0);
    check_hex("midrst.out_y", fwd_bus.data_y, 16'h0000);
    check("midrst.busy", int'(sts_busy), 0);
    check("midrst.frame_cnt", int'(sts_frame_cnt), 0);
    check("midrst.drop_cnt", int'(sts_drop_cnt), 0);
    rst = 1'b0;
    repeat (3) begin
      set_beat(1'b1);
      tick();
    end
    set_beat(1'b0);
    repeat (3) tick();
    check("midrst.resync", n_resync - b_resync, 0);
    check("midrst.fwd_beats", n_fwd - b_fwd, 0);
    check("midrst.err_line", n_eline - b_eline, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
